// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, paces instruction fetch over req/ack and issue over
// valid/ready, and applies the decoder's next-PC request when an instruction retires.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [2:0]  npc_op,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] retire_cnt,
    output logic        halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [2:0] OP_BEQ = 3'd1;
    localparam logic [2:0] OP_J   = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] next_pc;
    logic        retire;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        next_pc = pc4;
        case (npc_op)
            OP_BEQ:  if (zero) next_pc = pc4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
            OP_J:    next_pc = {pc_q[31:28], imm26, 2'b00};
            OP_JR:   next_pc = ra;
            default: next_pc = pc4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    // A misaligned target halts without retiring the instruction.
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        retire  = 1'b1;
                        state_d = en ? S_FETCH : S_IDLE;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign pc          = pc_q;
    assign retire_cnt  = retire_cnt_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized instruction streams,
// checked against a transaction-level model of the PC, retire count and halt flag.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  npc_op;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] retire_cnt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .npc_op     (npc_op),
        .imm26      (imm26),
        .ra         (ra),
        .zero       (zero),
        .pc         (pc),
        .pc4        (pc4),
        .retire_cnt (retire_cnt),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC: what the ISA says the target is, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] op,
                                             input logic [25:0] imm, input logic [31:0] r,
                                             input logic z);
        int off;
        off = int'($signed(imm[15:0]));
        case (op)
            3'd1:    return z ? cur + 32'd4 + 32'(off * 4) : cur + 32'd4;
            3'd2:    return (cur & 32'hF000_0000) + (32'(imm) * 32'd4);
            3'd3:    return r;
            default: return cur + 32'd4;
        endcase
    endfunction

    // Runs one instruction; the DUT must already be presenting a fetch this cycle.
    task automatic do_instr(input logic [2:0] op, input logic [25:0] imm, input logic [31:0] r,
                            input logic z, input int ack_wait, input int rdy_wait,
                            input logic en_ret);
        logic [31:0] word;
        logic [31:0] nxt;
        word = $urandom;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            en          = 1'($urandom_range(0, 1));
            cyc();
            check("ackwait_req", 32'(imem_req), 32'd1);
            check("ackwait_addr", imem_addr, m_pc);
        end
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'($urandom_range(0, 1));
        cyc();
        imem_ack    = 1'($urandom_range(0, 1));
        imem_rdata  = ~word;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_instr", instr, word);
        check("issue_req_low", 32'(imem_req), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            instr_ready = 1'b0;
            npc_op      = 3'($urandom);
            ra          = $urandom;
            en          = 1'($urandom_range(0, 1));
            cyc();
            check("rdywait_instr", instr, word);
            check("rdywait_valid", 32'(instr_valid), 32'd1);
        end
        npc_op      = op;
        imm26       = imm;
        ra          = r;
        zero        = z;
        en          = en_ret;
        instr_ready = 1'b1;
        check("pc4", pc4, m_pc + 32'd4);
        cyc();
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        nxt = ref_next(m_pc, op, imm, r, z);
        if (nxt[1:0] != 2'b00) begin
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_pc", pc, m_pc);
            check("halt_cnt", retire_cnt, m_cnt);
            check("halt_req", 32'(imem_req), 32'd0);
        end else begin
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
            check("retire_pc", pc, m_pc);
            check("retire_cnt", retire_cnt, m_cnt);
            check("retire_halted", 32'(halted), 32'd0);
            if (en_ret) begin
                check("refetch_req", 32'(imem_req), 32'd1);
                check("refetch_addr", imem_addr, m_pc);
            end else begin
                check("idle_req", 32'(imem_req), 32'd0);
                check("idle_valid", 32'(instr_valid), 32'd0);
            end
        end
    endtask

    // Sits in IDLE with handshake noise, then re-enables; ends in the first fetch cycle.
    task automatic resume(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            en          = 1'b0;
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            cyc();
            check("idle_hold_req", 32'(imem_req), 32'd0);
            check("idle_hold_pc", pc, m_pc);
        end
        en = 1'b1;
        cyc();
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        en          = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        npc_op      = 3'd0;
        imm26       = 26'd0;
        ra          = 32'd0;
        zero        = 1'b0;
        m_pc        = 32'h0000_3000;
        m_cnt       = 32'd0;

        cyc();
        cyc();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_pc4", pc4, 32'h0000_3004);
        check("rst_instr", instr, 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        reset = 1'b1;
        check("startup_idle_req", 32'(imem_req), 32'd0);
        cyc();
        check("startup_req", 32'(imem_req), 32'd1);
        check("startup_addr", imem_addr, 32'h0000_3000);

        for (int i = 0; i < 4; i++) do_instr(3'd0, 26'd0, 32'd0, 1'b0, 0, 0, 1'b1);
        check("seq_cnt4", retire_cnt, 32'd4);

        do_instr(3'd1, {10'h155, 16'hFFFE}, 32'd0, 1'b1, 0, 0, 1'b1);
        check("beq_back_addr", imem_addr, 32'h0000_300C);
        do_instr(3'd0, 26'd0, 32'd0, 1'b0, 0, 0, 1'b1);
        do_instr(3'd1, {10'h2AA, 16'hFFFE}, 32'd0, 1'b0, 0, 0, 1'b1);
        check("beq_nottaken_addr", imem_addr, 32'h0000_3014);
        do_instr(3'd3, 26'd0, 32'h0000_3010, 1'b0, 0, 0, 1'b1);
        do_instr(3'd1, 26'h0000003, 32'd0, 1'b1, 0, 0, 1'b1);
        check("beq_fwd_addr", imem_addr, 32'h0000_3020);

        do_instr(3'd3, 26'd0, 32'h0000_3000, 1'b0, 0, 0, 1'b1);
        do_instr(3'd2, 26'h0000C10, 32'd0, 1'b0, 0, 0, 1'b1);
        check("j_pc", pc, 32'h0000_3040);
        do_instr(3'd3, 26'd0, 32'h0000_3008, 1'b0, 0, 0, 1'b1);
        check("jr_pc", pc, 32'h0000_3008);

        do_instr(3'd0, 26'd0, 32'd0, 1'b0, 3, 2, 1'b0);
        resume(3);

        force dut.retire_cnt_d = 32'hFFFF_FFFF;
        cyc();
        release dut.retire_cnt_d;
        m_cnt = 32'hFFFF_FFFF;
        check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        do_instr(3'd0, 26'd0, 32'd0, 1'b0, 0, 0, 1'b1);
        check("wrap_cnt", retire_cnt, 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic en_r;
            en_r = ($urandom_range(0, 3) != 0);
            do_instr(3'($urandom_range(0, 7)), 26'($urandom), $urandom & 32'hFFFF_FFFC,
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), en_r);
            if (!en_r) resume($urandom_range(0, 2));
        end

        do_instr(3'd3, 26'd0, 32'h0000_3006, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            en          = 1'b1;
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            cyc();
            check("halt_stuck_req", 32'(imem_req), 32'd0);
            check("halt_stuck_flag", 32'(halted), 32'd1);
            check("halt_stuck_pc", pc, m_pc);
        end

        reset = 1'b0;
        cyc();
        check("rehalt_rst_pc", pc, 32'h0000_3000);
        check("rehalt_rst_halted", 32'(halted), 32'd0);
        check("rehalt_rst_cnt", retire_cnt, 32'd0);

        reset    = 1'b1;
        imem_ack = 1'b0;
        cyc();
        check("rstmid_fetch_req", 32'(imem_req), 32'd1);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        check("rstmid_instr", instr, 32'd0);
        check("rstmid_req", 32'(imem_req), 32'd0);
        check("rstmid_pc", pc, 32'h0000_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
